// File: rtl/rf_defs_pkg.sv
// ---------------------------------------------------------------------------
// rf_defs_pkg
// Shared register-file definitions for the GPR bank read path.
//   REG_ZERO / REG_SP / REG_RA : architecturally special register indices
//   SP_RESET_DEFAULT           : power-on value of the stack pointer ($29)
//   RF_DEPTH / RF_IDX_W        : number of entries and index width
//   rf_writable()              : true for any index that accepts writes
// ---------------------------------------------------------------------------
package rf_defs_pkg;

    localparam int          RF_DEPTH         = 32;
    localparam int          RF_IDX_W         = 5;
    localparam int          SP_RESET_DEFAULT = 227;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [4:0]  REG_SP   = 5'd29;
    localparam logic [4:0]  REG_RA   = 5'd31;

    // $0 is hard-wired to zero; every other index is a real storage entry.
    function automatic logic rf_writable(input logic [RF_IDX_W-1:0] idx);
        return idx != REG_ZERO;
    endfunction

endpackage

// File: rtl/operand_latch.sv
// ---------------------------------------------------------------------------
// operand_latch
// DATA_W-wide operand register with load enable, used for the A and B
// operand latches that sit between the register bank and the ALU muxes.
// Ports:
//   clk   in   1       clock, rising edge
//   rst   in   1       asynchronous active-high reset, clears q to 0
//   load  in   1       capture d at the next rising edge; otherwise hold
//   d     in   DATA_W  value to capture
//   q     out  DATA_W  registered value
// ---------------------------------------------------------------------------
module operand_latch #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_bank_read.sv
// ---------------------------------------------------------------------------
// register_bank_read
// 32-entry general-purpose register bank for the multicycle datapath: one
// write port (index from the write-register select mux), two combinational
// read ports (rs / rt) and the registered A/B operand latches.
// Optional feature macro: RF_BYPASS_EN
//   defined   - a write to the index being read appears on ReadDataN in the
//               same cycle, so a same-edge ALoad/BLoad captures the new value
//   undefined - reads show the old contents until the edge after the write
// Ports:
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous active-high reset
//   RegWrite   in   1       write strobe
//   WriteReg   in   5       write index ($0 writes are dropped)
//   WriteData  in   DATA_W  write data
//   ReadReg1   in   5       read index, port 1 (rs)
//   ReadReg2   in   5       read index, port 2 (rt)
//   ALoad      in   1       load A_out from ReadData1
//   BLoad      in   1       load B_out from ReadData2
//   ReadData1  out  DATA_W  combinational read, port 1
//   ReadData2  out  DATA_W  combinational read, port 2
//   A_out      out  DATA_W  operand latch A
//   B_out      out  DATA_W  operand latch B
// ---------------------------------------------------------------------------
module register_bank_read
    import rf_defs_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEFAULT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWrite,
    input  logic [RF_IDX_W-1:0] WriteReg,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [RF_IDX_W-1:0] ReadReg1,
    input  logic [RF_IDX_W-1:0] ReadReg2,
    input  logic                ALoad,
    input  logic                BLoad,
    output logic [DATA_W-1:0]   ReadData1,
    output logic [DATA_W-1:0]   ReadData2,
    output logic [DATA_W-1:0]   A_out,
    output logic [DATA_W-1:0]   B_out
);

    logic [DATA_W-1:0] regs [RF_DEPTH];
    logic              wr_en;

    assign wr_en = RegWrite && rf_writable(WriteReg);

    // Storage: reset forces the whole bank, so a write in flight is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs[i] <= (RF_IDX_W'(i) == REG_SP) ? SP_RESET : '0;
            end
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Read ports: $0 reads as zero regardless of array contents.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (ReadReg1 != REG_ZERO) begin
            ReadData1 = regs[ReadReg1];
        end
        if (ReadReg2 != REG_ZERO) begin
            ReadData2 = regs[ReadReg2];
        end
`ifdef RF_BYPASS_EN
        // Write-through: wr_en already excludes $0, so the zero rule holds.
        if (wr_en && (WriteReg == ReadReg1)) begin
            ReadData1 = WriteData;
        end
        if (wr_en && (WriteReg == ReadReg2)) begin
            ReadData2 = WriteData;
        end
`endif
    end

    operand_latch #(.DATA_W(DATA_W)) u_a_latch (
        .clk  (clk),
        .rst  (reset),
        .load (ALoad),
        .d    (ReadData1),
        .q    (A_out)
    );

    operand_latch #(.DATA_W(DATA_W)) u_b_latch (
        .clk  (clk),
        .rst  (reset),
        .load (BLoad),
        .d    (ReadData2),
        .q    (B_out)
    );

endmodule
